ext_mem_responder: RTL

//  Memory-side responder for the external word bus driven by the cache miss controller (re/wr/addr/data/ack).

---
 rtl/ext_mem_pkg.sv | 23 ++
 rtl/ext_mem_responder_if.sv | 38 +++
 rtl/ext_mem_array.sv | 27 ++
 rtl/ext_mem_responder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external memory responder: FSM state encoding,
// bus word geometry and the width of the programmable wait counter.
package ext_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LAT_CNT_W  = 8;

  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    ACK     = 3'd3,
    RECOVER = 3'd4
  } mem_state_e;

  // Counter load value for a wait of 'lat' cycles (lat >= 1).
  function automatic lat_cnt_t lat_load(input int lat);
    return lat_cnt_t'(lat - 1);
  endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// Word bus between the cache miss controller (master) and the memory
// responder (slave). Optional bus_err exists when EXT_MEM_RESP_ERR_EN is defined.
//
// Handshake: the master raises bus_re or bus_wr (level) with bus_addr and
// bus_wdata and holds the request until it sees bus_ack. bus_ack is a
// single-cycle completion pulse; bus_rdata (and bus_err) are meaningful only
// while bus_ack is high. Dropping the request before bus_ack aborts the access.
interface ext_mem_responder_if #(
  parameter int WORD_SIZE = 32
);
  logic [31:0]          bus_addr;
  logic [WORD_SIZE-1:0] bus_wdata;
  logic                 bus_re;
  logic                 bus_wr;
  logic [WORD_SIZE-1:0] bus_rdata;
  logic                 bus_ack;
`ifdef EXT_MEM_RESP_ERR_EN
  logic                 bus_err;

  modport master (
    output bus_addr, bus_wdata, bus_re, bus_wr,
    input  bus_rdata, bus_ack, bus_err
  );
  modport slave (
    input  bus_addr, bus_wdata, bus_re, bus_wr,
    output bus_rdata, bus_ack, bus_err
  );
`else
  modport master (
    output bus_addr, bus_wdata, bus_re, bus_wr,
    input  bus_rdata, bus_ack
  );
  modport slave (
    input  bus_addr, bus_wdata, bus_re, bus_wr,
    output bus_rdata, bus_ack
  );
`endif
endinterface

// File: rtl/ext_mem_array.sv
// Synchronous single-port word RAM: write on we, registered read on re.
// Contents are not reset; they persist across responder resets.
module ext_mem_array #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_WORDS = 1024,
  parameter int IDX_BITS  = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [IDX_BITS-1:0]  idx,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [MEM_WORDS];
  logic [WORD_SIZE-1:0] rdata_q;

  // Single port: write commit and read fetch share the latched index.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Memory-side responder for the external word bus. Accepts one read or write,
// waits a programmable number of cycles, pulses bus_ack once, then spends one
// RECOVER cycle before looking at the bus again.
// Optional feature: EXT_MEM_RESP_ERR_EN adds bus_err for byte addresses at or
// beyond MEM_WORDS*4; without it addresses wrap modulo MEM_WORDS.
// MEM_WORDS is expected to be a power of two.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int MEM_WORDS     = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  ext_mem_responder_if.slave  bus,
  output logic                busy,
  output mem_state_e          dbg_state
);

  localparam int       MEM_IDX_BITS = $clog2(MEM_WORDS);
  localparam lat_cnt_t RD_LOAD      = lat_load(READ_LATENCY);
  localparam lat_cnt_t WR_LOAD      = lat_load(WRITE_LATENCY);

  mem_state_e               state_q, state_d;
  lat_cnt_t                 cnt_q, cnt_d;
  logic [MEM_IDX_BITS-1:0]  idx_q, idx_d;
  logic [WORD_SIZE-1:0]     wdata_q, wdata_d;
  logic                     op_rd_q, op_rd_d;
  logic                     err_q, err_d;

  logic                     ram_we;
  logic                     ram_re;
  logic [WORD_SIZE-1:0]     ram_rdata;
  logic [MEM_IDX_BITS-1:0]  bus_idx;
  logic                     req_err;

  assign bus_idx = bus.bus_addr[MEM_IDX_BITS+1:2];

`ifdef EXT_MEM_RESP_ERR_EN
  logic unused_addr_bits;
  assign req_err          = (bus.bus_addr >= 32'(MEM_WORDS * WORD_BYTES));
  assign unused_addr_bits = ^bus.bus_addr[1:0];
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{bus.bus_addr[31:MEM_IDX_BITS+2], bus.bus_addr[1:0]};
`endif

  // State, counter and request latches; reset drops any pending access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_rd_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_rd_q <= op_rd_d;
      err_q   <= err_d;
    end
  end

  // Next state: accept (write wins), count down, abort on dropped request,
  // fire the RAM access on the edge that enters ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_rd_d = op_rd_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.bus_wr) begin
          state_d = WR_WAIT;
          cnt_d   = WR_LOAD;
          idx_d   = bus_idx;
          wdata_d = bus.bus_wdata;
          op_rd_d = 1'b0;
          err_d   = req_err;
        end else if (bus.bus_re) begin
          state_d = RD_WAIT;
          cnt_d   = RD_LOAD;
          idx_d   = bus_idx;
          op_rd_d = 1'b1;
          err_d   = req_err;
        end
      end
      RD_WAIT: begin
        if (!bus.bus_re) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACK;
          ram_re  = !err_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_WAIT: begin
        if (!bus.bus_wr) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACK;
          ram_we  = !err_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK:     state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  ext_mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .MEM_WORDS (MEM_WORDS),
    .IDX_BITS  (MEM_IDX_BITS)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Read data is only presented during the ACK cycle of an in-range read.
  assign bus.bus_ack   = (state_q == ACK);
  assign bus.bus_rdata = (state_q == ACK && op_rd_q && !err_q) ? ram_rdata : '0;
`ifdef EXT_MEM_RESP_ERR_EN
  assign bus.bus_err   = (state_q == ACK) && err_q;
`endif
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule
